// File: rtl/sudoku_cursor_ctrl.sv
// Cursor, row-fetch and protected cell-write controller for an N x N Sudoku board.
// Each RAM word holds one row: write-protect bits above the packed digit field.
module sudoku_cursor_ctrl #(
  parameter int N  = 4,
  parameter int DW = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = N + N * DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] userNum,
  input  logic          upButton,
  input  logic          downButton,
  input  logic          leftButton,
  input  logic          rightButton,
  input  logic          writeBit,
  output logic [N*DW-1:0] currentRow,
  output logic [N-1:0]  currentNum,
  output logic [AW-1:0] RamAddr,
  input  logic [RW-1:0] RamDat,
  output logic [RW-1:0] RamWrDat,
  output logic          RamWriteBit,
  output logic          busy,
  output logic          writeReject
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] IDLE  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [AW-1:0] LAST_ROW    = AW'(N - 1);
  localparam logic [DW-1:0] MAX_DIGIT   = DW'(N);
  localparam logic [N-1:0]  CURSOR_HOME = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic          upPrev, downPrev, leftPrev, rightPrev, writePrev;
  logic          upRise, downRise, leftRise, rightRise, writeRise;
  logic [RW-1:0] rowBuf;
  logic [RW-1:0] mergedRow;
  logic          protectHit;
  logic          digitOk;

  // Explicit wrap compares: N is not necessarily a power of two.
  function automatic logic [AW-1:0] rowAbove(input logic [AW-1:0] row);
    return (row == '0) ? LAST_ROW : row - AW'(1);
  endfunction

  function automatic logic [AW-1:0] rowBelow(input logic [AW-1:0] row);
    return (row == LAST_ROW) ? '0 : row + AW'(1);
  endfunction

  // Cursor bit i selects digit slice i, so the one-hot cursor doubles as the merge mask.
  function automatic logic [RW-1:0] mergeDigit(input logic [RW-1:0] row,
                                               input logic [N-1:0]  cursor,
                                               input logic [DW-1:0] digit);
    logic [RW-1:0] merged;
    merged = row;
    for (int i = 0; i < N; i++) begin
      if (cursor[i]) merged[i*DW +: DW] = digit;
    end
    return merged;
  endfunction

  assign upRise    = upButton    & ~upPrev;
  assign downRise  = downButton  & ~downPrev;
  assign leftRise  = leftButton  & ~leftPrev;
  assign rightRise = rightButton & ~rightPrev;
  assign writeRise = writeBit    & ~writePrev;

  assign protectHit = |(rowBuf[RW-1:N*DW] & currentNum);
  assign digitOk    = (userNum <= MAX_DIGIT);
  assign mergedRow  = mergeDigit(rowBuf, currentNum, userNum);

  assign busy        = (state != IDLE);
  assign RamWriteBit = (state == WRITE);
  assign RamWrDat    = rowBuf;
  assign currentRow  = rowBuf[N*DW-1:0];

  // Previous-value registers reset high so levels held through reset never fire.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      upPrev    <= 1'b1;
      downPrev  <= 1'b1;
      leftPrev  <= 1'b1;
      rightPrev <= 1'b1;
      writePrev <= 1'b1;
    end else begin
      upPrev    <= upButton;
      downPrev  <= downButton;
      leftPrev  <= leftButton;
      rightPrev <= rightButton;
      writePrev <= writeBit;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= FETCH;
      RamAddr     <= '0;
      currentNum  <= CURSOR_HOME;
      rowBuf      <= '0;
      writeReject <= 1'b0;
    end else begin
      writeReject <= 1'b0;
      case (state)
        FETCH: state <= LOAD;
        LOAD: begin
          rowBuf <= RamDat;
          state  <= IDLE;
        end
        IDLE: begin
          // Only the highest-priority edge of a cycle is acted on; the rest are dropped.
          if (writeRise) begin
            if (protectHit || !digitOk) begin
              writeReject <= 1'b1;
            end else begin
              rowBuf <= mergedRow;
              state  <= WRITE;
            end
          end else if (leftRise) begin
            currentNum <= {currentNum[N-2:0], currentNum[N-1]};
          end else if (rightRise) begin
            currentNum <= {currentNum[0], currentNum[N-1:1]};
          end else if (upRise) begin
            RamAddr <= rowAbove(RamAddr);
            state   <= FETCH;
          end else if (downRise) begin
            RamAddr <= rowBelow(RamAddr);
            state   <= FETCH;
          end
        end
        WRITE: state <= IDLE;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
